// File: rtl/arbitro_ram.sv
// arbitro_ram: two-requester arbiter in front of a single-port synchronous RAM.
// Each access takes IDLE -> GRANT -> WAIT, so the RAM is driven in GRANT and
// the requester sees done in WAIT.
// Build option: define ARB_RR_EN for round-robin priority on simultaneous
// requests. Without it, A always wins a tie and no pointer register exists.
module arbitro_ram #(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_a_i,
  input  logic         req_b_i,
  input  logic         wr_a_i,
  input  logic         wr_b_i,
  input  logic [N-1:0] addr_a_i,
  input  logic [N-1:0] addr_b_i,
  input  logic [M-1:0] dato_a_i,
  input  logic [M-1:0] dato_b_i,
  output logic         gnt_a_o,
  output logic         gnt_b_o,
  output logic         done_a_o,
  output logic         done_b_o,
  output logic [M-1:0] dato_a_o,
  output logic [M-1:0] dato_b_o,
  output logic [N-1:0] addr_o,
  output logic [M-1:0] dato_write_o,
  output logic         rden_o,
  output logic         wren_o,
  input  logic [M-1:0] dato_read_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic           win_b_q, win_b_d;   // 1 = current access belongs to B
  logic           wr_q, wr_d;         // latched write/read selector
  logic [N-1:0]   addr_q, addr_d;     // latched address, also drives addr_o
  logic [M-1:0]   wdat_q, wdat_d;     // latched write data, also drives dato_write_o
  logic [M-1:0]   rd_a_q, rd_a_d;     // read data returned to A
  logic [M-1:0]   rd_b_q, rd_b_d;     // read data returned to B
  logic           pick_b;             // arbitration result for this cycle
  logic           arb_fire;           // an arbitration happens this cycle

  assign arb_fire = (state_q == S_IDLE) && (req_a_i || req_b_i);

`ifdef ARB_RR_EN
  logic prio_b_q, prio_b_d;           // 1 = B wins the next tie

  // Lone request always wins; on a tie the pointer picks the winner.
  always_comb pick_b = req_b_i & (~req_a_i | prio_b_q);

  // Pointer moves on every arbitration, pointing at the side that lost.
  always_comb begin
    prio_b_d = prio_b_q;
    if (arb_fire) begin
      prio_b_d = ~pick_b;
    end
  end

  // Pointer register, starts by favouring A.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_b_q <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
    end
  end
`else
  // Fixed priority: B only wins when A is not asking.
  always_comb pick_b = req_b_i & ~req_a_i;
`endif

  // State and datapath registers; reset clears everything, aborting any access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      win_b_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      win_b_q <= win_b_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  // Next state, request latching, RAM strobes and handshake pulses.
  always_comb begin
    state_d  = state_q;
    win_b_d  = win_b_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    rd_a_d   = rd_a_q;
    rd_b_d   = rd_b_q;
    gnt_a_o  = 1'b0;
    gnt_b_o  = 1'b0;
    done_a_o = 1'b0;
    done_b_o = 1'b0;
    rden_o   = 1'b0;
    wren_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_fire) begin
          state_d = S_GRANT;
          win_b_d = pick_b;
          wr_d    = pick_b ? wr_b_i   : wr_a_i;
          addr_d  = pick_b ? addr_b_i : addr_a_i;
          wdat_d  = pick_b ? dato_b_i : dato_a_i;
        end
      end
      S_GRANT: begin
        gnt_a_o = ~win_b_q;
        gnt_b_o = win_b_q;
        wren_o  = wr_q;
        rden_o  = ~wr_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        done_a_o = ~win_b_q;
        done_b_o = win_b_q;
        if (!wr_q) begin
          if (win_b_q) begin
            rd_b_d = dato_read_i;
          end else begin
            rd_a_d = dato_read_i;
          end
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read data is presented from the capture mux so it is already valid in the
  // done cycle (RAM data only arrives in WAIT); afterwards the register holds it.
  assign dato_a_o     = rd_a_d;
  assign dato_b_o     = rd_b_d;
  assign addr_o       = addr_q;
  assign dato_write_o = wdat_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_arbitro_ram.sv
// Testbench for arbitro_ram: directed scenarios plus a randomized run checked
// against a transaction-level reference (arbitration rule + memory array).
module tb_arbitro_ram;
  localparam int N = 4;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_a, req_b, wr_a, wr_b;
  logic [N-1:0] addr_a, addr_b;
  logic [M-1:0] din_a, din_b;
  logic         gnt_a, gnt_b, done_a, done_b;
  logic [M-1:0] dout_a, dout_b;
  logic [N-1:0] ram_addr;
  logic [M-1:0] ram_wd;
  logic         rden, wren, busy;
  logic [M-1:0] ram_rd;

  int checks = 0;
  int passed = 0;

  logic [M-1:0] ref_mem [16];
  bit           written [16];
  logic [M-1:0] ram     [16];

  arbitro_ram #(.N(N), .M(M)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .req_b_i(req_b), .wr_a_i(wr_a), .wr_b_i(wr_b),
    .addr_a_i(addr_a), .addr_b_i(addr_b), .dato_a_i(din_a), .dato_b_i(din_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .done_a_o(done_a), .done_b_o(done_b),
    .dato_a_o(dout_a), .dato_b_o(dout_b), .addr_o(ram_addr),
    .dato_write_o(ram_wd), .rden_o(rden), .wren_o(wren),
    .dato_read_i(ram_rd), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Synchronous RAM attached to the arbiter: data one cycle after rden.
  always @(posedge clk) begin
    if (wren) ram[ram_addr] <= ram_wd;
    if (rden) ram_rd <= ram[ram_addr];
  end

  task automatic drive_idle();
    req_a = 0; req_b = 0; wr_a = 0; wr_b = 0;
    addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // Issue one access from an idle arbiter and record what was observed.
  task automatic access(input bit use_b, input bit wr, input logic [3:0] addr,
                        input logic [3:0] data, output int lat_g, output int lat_d,
                        output bit saw_wr, output bit saw_rd, output logic [3:0] g_addr,
                        output logic [3:0] g_wd, output logic [3:0] rdata);
    lat_g = -1; lat_d = -1; saw_wr = 0; saw_rd = 0;
    g_addr = '0; g_wd = '0; rdata = '0;
    if (use_b) begin req_b = 1; wr_b = wr; addr_b = addr; din_b = data; end
    else       begin req_a = 1; wr_a = wr; addr_a = addr; din_a = data; end
    for (int k = 1; k <= 8 && lat_d < 0; k++) begin
      @(posedge clk); #1;
      if ((use_b ? gnt_b : gnt_a) && lat_g < 0) begin
        lat_g = k; saw_wr = wren; saw_rd = rden; g_addr = ram_addr; g_wd = ram_wd;
      end
      if (use_b ? done_b : done_a) begin
        lat_d = k; rdata = use_b ? dout_b : dout_a;
      end
    end
    req_a = 0; req_b = 0;
    $display("txn %s %s addr=%h data=%h gnt@%0d done@%0d rdata=%h",
             use_b ? "B" : "A", wr ? "wr" : "rd", addr, data, lat_g, lat_d, rdata);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt_a, gnt_b, done_a, done_b, rden, wren, busy} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want %b", {gnt_a, gnt_b, done_a, done_b, rden, wren, busy}, 7'b0);
    else passed++;
    checks++;
    if ({ram_addr, ram_wd, dout_a, dout_b} !== 16'h0)
      $display("FAIL reset_data: got %h want %h", {ram_addr, ram_wd, dout_a, dout_b}, 16'h0);
    else passed++;
    rst = 0;
  endtask

  task automatic test_write_then_read();
    int lg, ld; bit sw, sr; logic [3:0] ga, gw, rd;
    access(0, 1, 4'h3, 4'hA, lg, ld, sw, sr, ga, gw, rd);
    checks++;
    if (lg !== 1 || ld !== 2) $display("FAIL wr_latency: got gnt=%0d done=%0d want 1 2", lg, ld);
    else passed++;
    checks++;
    if ({sw, sr, ga, gw} !== {2'b10, 4'h3, 4'hA})
      $display("FAIL wr_bus: got wr/rd=%b%b addr=%h wd=%h want 10 3 a", sw, sr, ga, gw);
    else passed++;
    access(0, 0, 4'h3, 4'h0, lg, ld, sw, sr, ga, gw, rd);
    checks++;
    if ({sw, sr, ga} !== {2'b01, 4'h3} || rd !== 4'hA)
      $display("FAIL rd_back: got wr/rd=%b%b addr=%h data=%h want 01 3 a", sw, sr, ga, rd);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dout_a !== 4'hA || dout_b !== 4'h0)
      $display("FAIL rd_hold: got a=%h b=%h want a 0", dout_a, dout_b);
    else passed++;
  endtask

  task automatic test_latency();
    int lg, ld; bit sw, sr; logic [3:0] ga, gw, rd;
    access(1, 1, 4'hF, 4'h5, lg, ld, sw, sr, ga, gw, rd);
    access(1, 0, 4'hF, 4'h0, lg, ld, sw, sr, ga, gw, rd);
    checks++;
    if (lg !== 1 || sr !== 1'b1 || sw !== 1'b0)
      $display("FAIL lat_gnt: got gnt=%0d rden=%b wren=%b want 1 1 0", lg, sr, sw);
    else passed++;
    checks++;
    if (ld !== 2 || rd !== 4'h5) $display("FAIL lat_done: got done=%0d data=%h want 2 5", ld, rd);
    else passed++;
  endtask

  task automatic test_isolation();
    int lg, ld; bit sw, sr; logic [3:0] ga, gw, rd;
    access(0, 1, 4'h7, 4'h3, lg, ld, sw, sr, ga, gw, rd);
    access(0, 0, 4'h7, 4'h0, lg, ld, sw, sr, ga, gw, rd);
    checks++;
    if (rd !== 4'h3) $display("FAIL iso_read: got %h want 3", rd);
    else passed++;
    access(1, 1, 4'h7, 4'hC, lg, ld, sw, sr, ga, gw, rd);
    checks++;
    if (dout_a !== 4'h3 || dout_b !== 4'h5)
      $display("FAIL iso_write: got a=%h b=%h want 3 5", dout_a, dout_b);
    else passed++;
    access(1, 0, 4'h7, 4'h0, lg, ld, sw, sr, ga, gw, rd);
    checks++;
    if (dout_b !== 4'hC || dout_a !== 4'h3)
      $display("FAIL iso_b_read: got a=%h b=%h want 3 c", dout_a, dout_b);
    else passed++;
  endtask

  task automatic test_drop();
    int ga_n = 0, da_n = 0, gb_n = 0, wr_n = 0;
    logic [3:0] cap = '0;
    req_a = 1; wr_a = 0; addr_a = 4'h3;
    @(posedge clk); #1;
    if (gnt_a) ga_n++;
    req_a = 0;
    req_b = 1; wr_b = 1; addr_b = 4'h0; din_b = 4'h9;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (gnt_a) ga_n++;
      if (gnt_b) gb_n++;
      if (wren) wr_n++;
      if (done_a) begin da_n++; cap = dout_a; end
      if (i == 0) req_b = 0;
    end
    checks++;
    if (ga_n !== 1 || da_n !== 1 || cap !== 4'hA)
      $display("FAIL drop_latched: got gnt=%0d done=%0d data=%h want 1 1 a", ga_n, da_n, cap);
    else passed++;
    checks++;
    if (gb_n !== 0 || wr_n !== 0)
      $display("FAIL drop_ignored: got gnt_b=%0d writes=%0d want 0 0", gb_n, wr_n);
    else passed++;
  endtask

  task automatic test_reset_in_grant();
    int dn = 0;
    req_a = 1; wr_a = 1; addr_a = 4'h9; din_a = 4'h6;
    @(posedge clk); #1;
    checks++;
    if (wren !== 1'b1 || gnt_a !== 1'b1) $display("FAIL rg_setup: got wren=%b gnt=%b want 1 1", wren, gnt_a);
    else passed++;
    #2 rst = 1;
    #1;
    checks++;
    if ({gnt_a, gnt_b, done_a, done_b, rden, wren, busy, ram_addr, ram_wd, dout_a, dout_b} !== 23'h0)
      $display("FAIL rg_async: got %h want 0", {gnt_a, gnt_b, done_a, done_b, rden, wren, busy, ram_addr, ram_wd, dout_a, dout_b});
    else passed++;
    req_a = 0;
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done_a || done_b) dn++;
    end
    checks++;
    if (dn !== 0 || busy !== 1'b0) $display("FAIL rg_after: got done=%0d busy=%b want 0 0", dn, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit gq[$];
    int tq[$];
    bit exp_w;
    do_reset();
    req_a = 1; wr_a = 1; addr_a = 4'h1; din_a = 4'h1;
    req_b = 1; wr_b = 1; addr_b = 4'h2; din_b = 4'h2;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      checks++;
      if (gnt_a && gnt_b) $display("FAIL b2b_both: cycle %0d got both grants want one", cyc);
      else passed++;
      if (gnt_a || gnt_b) begin gq.push_back(gnt_b); tq.push_back(cyc); end
    end
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (gq.size() !== 10) $display("FAIL b2b_count: got %0d grants want 10", gq.size());
    else passed++;
    for (int i = 0; i < gq.size(); i++) begin
`ifdef ARB_RR_EN
      exp_w = (i % 2) == 1;
`else
      exp_w = 1'b0;
`endif
      checks++;
      if (gq[i] !== exp_w) $display("FAIL b2b_order: grant %0d got B=%b want B=%b", i, gq[i], exp_w);
      else passed++;
      checks++;
      if (tq[i] !== 1 + 3 * i) $display("FAIL b2b_time: grant %0d got cycle %0d want %0d", i, tq[i], 1 + 3 * i);
      else passed++;
    end
  endtask

  task automatic test_random();
    int m_left = 0;
    bit m_win = 0, m_wr = 0;
    logic [3:0] m_addr = '0;
    logic [3:0] exp_addr = '0, exp_wd = '0, exp_da = '0, exp_db = '0;
    bit e_ga, e_gb, e_da, e_db, e_rd, e_wr, e_busy, ra, rb;
    bit pend_a = 0, pend_b = 0;
    logic [3:0] na;
`ifdef ARB_RR_EN
    bit m_prio_b = 0;
`endif
    do_reset();
    for (int i = 0; i < 16; i++) written[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      ra = req_a; rb = req_b;
      {e_ga, e_gb, e_da, e_db, e_rd, e_wr, e_busy} = '0;
      if (m_left == 2) begin
        e_da = !m_win; e_db = m_win; e_busy = 1; m_left = 1;
        if (!m_wr) begin
          if (m_win) exp_db = ref_mem[m_addr]; else exp_da = ref_mem[m_addr];
        end
        $display("txn %s %s addr=%h data=%h", m_win ? "B" : "A", m_wr ? "wr" : "rd",
                 m_addr, m_wr ? exp_wd : ref_mem[m_addr]);
      end else if (m_left == 1) begin
        m_left = 0;
      end else if (ra || rb) begin
        if (ra && rb) begin
`ifdef ARB_RR_EN
          m_win = m_prio_b;
`else
          m_win = 0;
`endif
        end else m_win = rb;
`ifdef ARB_RR_EN
        m_prio_b = !m_win;
`endif
        m_wr = m_win ? wr_b : wr_a;
        m_addr = m_win ? addr_b : addr_a;
        exp_addr = m_addr;
        exp_wd = m_win ? din_b : din_a;
        e_ga = !m_win; e_gb = m_win; e_busy = 1; m_left = 2;
        if (m_wr) begin e_wr = 1; ref_mem[m_addr] = exp_wd; written[m_addr] = 1; end
        else e_rd = 1;
      end
      checks++;
      if ({gnt_a, gnt_b, done_a, done_b, rden, wren, busy} !== {e_ga, e_gb, e_da, e_db, e_rd, e_wr, e_busy})
        $display("FAIL rnd_ctrl: cycle %0d got %b want %b", cyc,
                 {gnt_a, gnt_b, done_a, done_b, rden, wren, busy}, {e_ga, e_gb, e_da, e_db, e_rd, e_wr, e_busy});
      else passed++;
      checks++;
      if ({ram_addr, ram_wd} !== {exp_addr, exp_wd})
        $display("FAIL rnd_bus: cycle %0d got addr=%h wd=%h want %h %h", cyc, ram_addr, ram_wd, exp_addr, exp_wd);
      else passed++;
      checks++;
      if ({dout_a, dout_b} !== {exp_da, exp_db})
        $display("FAIL rnd_rdata: cycle %0d got a=%h b=%h want %h %h", cyc, dout_a, dout_b, exp_da, exp_db);
      else passed++;
      if (e_da) pend_a = 0;
      if (e_db) pend_b = 0;
      if (!pend_a && $urandom_range(0, 9) < 6) begin
        na = 4'($urandom_range(0, 15));
        pend_a = 1; addr_a = na; din_a = 4'($urandom_range(0, 15));
        wr_a = written[na] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!pend_b && $urandom_range(0, 9) < 6) begin
        na = 4'($urandom_range(0, 15));
        pend_b = 1; addr_b = na; din_b = 4'($urandom_range(0, 15));
        wr_b = written[na] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      req_a = pend_a; req_b = pend_b;
    end
    drive_idle();
    repeat (4) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_latency();
    test_isolation();
    test_drop();
    test_reset_in_grant();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
